// File: rtl/operate_channel_arbiter.sv
// Two-requester arbiter for the 8-bit traveler operation channel: holds each command frame, then a null gap.
// Build option: define OPERATE_MANUAL_PRIORITY_EN for fixed manual priority instead of round-robin.
module operate_channel_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             man_valid,
    input  logic [4:0]       man_op,
    output logic             man_ready,
    input  logic             scr_valid,
    input  logic [4:0]       scr_op,
    output logic             scr_ready,
    input  logic             scr_enable,
    output logic [7:0]       data,
    output logic             busy,
    output logic             grant_src,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cmd_count
);
    localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [7:0] NULL_FRAME = 8'b0_00000_10;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [4:0]       op_reg, op_next;
    logic             grant_reg, grant_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic       idle;
    logic       scr_req;
    logic       sel_scr;
    logic       accept;
    logic [4:0] acc_op;
    logic       op_ok;

    assign idle    = (state_reg == IDLE);
    assign scr_req = scr_valid & scr_enable;

`ifdef OPERATE_MANUAL_PRIORITY_EN
    assign sel_scr = scr_req & ~man_valid;
`else
    // ptr_reg = 1 means script was granted last; resets to script so manual wins first contention
    logic ptr_reg;
    assign sel_scr = (scr_req & man_valid) ? ~ptr_reg : scr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b1;
        end else if (accept) begin
            ptr_reg <= sel_scr;
        end
    end
`endif

    assign man_ready = idle & man_valid & ~sel_scr;
    assign scr_ready = idle & sel_scr;
    assign accept    = man_ready | scr_ready;
    assign acc_op    = sel_scr ? scr_op : man_op;
    assign op_ok     = (acc_op != 5'd0) && ((acc_op & (acc_op - 5'd1)) == 5'd0);

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        op_next    = op_reg;
        grant_next = grant_reg;
        err_next   = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    grant_next = sel_scr;
                    if (op_ok) begin
                        op_next    = acc_op;
                        state_next = HOLD;
                        tmr_next   = HOLD_LOAD;
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end else begin
                        // malformed op is consumed and dropped
                        err_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tmr_reg == '0) begin
                    state_next = GAP;
                    tmr_next   = GAP_LOAD;
                end else begin
                    tmr_next = tmr_reg - TMR_W'(1);
                end
            end
            GAP: begin
                if (tmr_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr_reg - TMR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            tmr_reg   <= '0;
            op_reg    <= '0;
            grant_reg <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
            op_reg    <= op_next;
            grant_reg <= grant_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign data      = (state_reg == HOLD) ? {1'b0, op_reg, 2'b10} : NULL_FRAME;
    assign busy      = ~idle;
    assign grant_src = grant_reg;
    assign err_pulse = err_reg;
    assign cmd_count = cnt_reg;

endmodule

// File: tb/tb_operate_channel_arbiter.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic against a schedule model.
module tb_operate_channel_arbiter;
    localparam int H = 4;
    localparam int G = 2;
    localparam logic [7:0] NUL = 8'h02;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic man_valid = 1'b0;
    logic [4:0] man_op = 5'd0;
    logic scr_valid = 1'b0;
    logic [4:0] scr_op = 5'd0;
    logic scr_enable = 1'b0;

    logic man_ready, scr_ready, busy, grant_src, err_pulse;
    logic [7:0] data;
    logic [15:0] cmd_count;
    logic man_ready4, scr_ready4, busy4, grant_src4, err_pulse4;
    logic [7:0] data4;
    logic [3:0] cmd_count4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operate_channel_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .man_valid(man_valid), .man_op(man_op), .man_ready(man_ready),
        .scr_valid(scr_valid), .scr_op(scr_op), .scr_ready(scr_ready),
        .scr_enable(scr_enable), .data(data), .busy(busy),
        .grant_src(grant_src), .err_pulse(err_pulse), .cmd_count(cmd_count)
    );

    operate_channel_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .man_valid(man_valid), .man_op(man_op), .man_ready(man_ready4),
        .scr_valid(scr_valid), .scr_op(scr_op), .scr_ready(scr_ready4),
        .scr_enable(scr_enable), .data(data4), .busy(busy4),
        .grant_src(grant_src4), .err_pulse(err_pulse4), .cmd_count(cmd_count4)
    );

    // Schedule model: cycle indices at which the channel frees up, the hold window ends, an error pulse is due
    int cyc = 0;
    int free_cycle = 0;
    int hold_end = -1;
    int err_cycle = -1;
    logic [4:0] m_op = 5'd0;
    logic m_last_scr = 1'b1;
    logic m_gsrc = 1'b0;
    int m_cnt = 0;
    logic a_acc, a_src;
    logic [4:0] a_op;
    int grant_log[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        free_cycle = cyc;
        hold_end   = -1;
        err_cycle  = -1;
        m_last_scr = 1'b1;
        m_gsrc     = 1'b0;
        m_cnt      = 0;
        m_op       = 5'd0;
    endtask

    task automatic apply(input logic mv, input logic [4:0] mop, input logic sv,
                         input logic [4:0] sop, input logic se);
        man_valid  = mv;
        man_op     = mop;
        scr_valid  = sv;
        scr_op     = sop;
        scr_enable = se;
        #4;
    endtask

    task automatic model_check();
        logic idle, mreq, sreq;
        logic [7:0] e_data;
        idle  = (cyc >= free_cycle);
        mreq  = man_valid;
        sreq  = scr_valid && scr_enable;
        a_acc = idle && (mreq || sreq);
        if (mreq && sreq) begin
`ifdef OPERATE_MANUAL_PRIORITY_EN
            a_src = 1'b0;
`else
            a_src = !m_last_scr;
`endif
        end else begin
            a_src = sreq;
        end
        a_op   = a_src ? scr_op : man_op;
        e_data = (cyc <= hold_end) ? {1'b0, m_op, 2'b10} : NUL;
        chk("man_ready", man_ready, a_acc && !a_src);
        chk("scr_ready", scr_ready, a_acc && a_src);
        chk("data", data, e_data);
        chk("busy", busy, !idle);
        chk("err_pulse", err_pulse, cyc == err_cycle);
        chk("grant_src", grant_src, m_gsrc);
        chk("cmd_count", cmd_count, m_cnt % 65536);
    endtask

    task automatic model_advance();
        @(posedge clk);
        #1;
        if (a_acc) begin
            m_gsrc     = a_src;
            m_last_scr = a_src;
            grant_log.push_back(int'(a_src));
            if ($countones(a_op) == 1) begin
                m_op       = a_op;
                hold_end   = cyc + H;
                free_cycle = cyc + H + G + 1;
                m_cnt++;
            end else begin
                err_cycle = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic step(input logic mv, input logic [4:0] mop, input logic sv,
                        input logic [4:0] sop, input logic se);
        apply(mv, mop, sv, sop, se);
        model_check();
        model_advance();
    endtask

    // Inputs applied before calling are held through reset
    task automatic do_reset();
        rst = 1'b1;
        #4;
        chk("rst_data", data, NUL);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       mv;
        logic [4:0] mop;
        logic       sv;
        logic [4:0] sop;
        logic       se;
        logic       mr;
        logic       sr;
        logic [7:0] dat;
        logic       bz;
        logic       er;
        logic       gs;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b1, 5'h08, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'h01, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'h01, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'h03, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'h00, 1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'h00, 1'b1, 5'h10, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'h00, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};

        @(posedge clk);
        #1;
        do_reset();

        // Directed table: single command, held request, invalid op, masked script, enable drop in HOLD
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].mv, tbl[i].mop, tbl[i].sv, tbl[i].sop, tbl[i].se);
            model_check();
            chk($sformatf("tbl%0d_man_ready", i), man_ready, tbl[i].mr);
            chk($sformatf("tbl%0d_scr_ready", i), scr_ready, tbl[i].sr);
            chk($sformatf("tbl%0d_data", i), data, tbl[i].dat);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
            chk($sformatf("tbl%0d_err", i), err_pulse, tbl[i].er);
            chk($sformatf("tbl%0d_grant", i), grant_src, tbl[i].gs);
            model_advance();
        end
        chk("tbl_cmd_count", cmd_count, 2);

        // Contention: both requesters valid continuously
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 21; i++) step(1'b1, 5'h01, 1'b1, 5'h10, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0);
        chk("arb_grants", grant_log.size(), 3);
        for (int k = 0; k < grant_log.size() && k < 3; k++) begin
`ifdef OPERATE_MANUAL_PRIORITY_EN
            chk($sformatf("arb_grant%0d", k), grant_log[k], 0);
`else
            chk($sformatf("arb_grant%0d", k), grant_log[k], k % 2);
`endif
        end

        // Reset two cycles into HOLD with a pending request held across it
        step(1'b1, 5'h04, 1'b0, 5'h00, 1'b0);
        step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0);
        step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0);
        man_valid = 1'b1;
        man_op    = 5'h02;
        do_reset();
        apply(1'b1, 5'h02, 1'b0, 5'h00, 1'b0);
        chk("post_rst_ready", man_ready, 1);
        model_check();
        model_advance();
        for (int i = 0; i < 7; i++) step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0);

        // Counter wrap: 17 back-to-back commands
        do_reset();
        for (int i = 0; i < 17 * (H + G + 1); i++) step(1'b1, 5'h01, 1'b0, 5'h00, 1'b0);
        step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0);
        chk("wrap_cnt4", cmd_count4, 1);
        chk("wrap_cnt16", cmd_count, 17);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [4:0] mo, so;
            mo = ($urandom_range(0, 3) != 0) ? (5'b00001 << $urandom_range(0, 4)) : 5'($urandom);
            so = ($urandom_range(0, 3) != 0) ? (5'b00001 << $urandom_range(0, 4)) : 5'($urandom);
            step(1'($urandom), mo, 1'($urandom), so, ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
